// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the KGP RISC core.
// Holds the IR, drives datapath strobes and counts retired instructions.
module multicycle_sequencer #(
    parameter int          MEM_TIMEOUT = 15,
    parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        data_read,
    input  logic        data_write,
    input  logic        reg_write,
    input  logic [2:0]  branch_type,
    input  logic        branch_taken,
    output logic [5:0]  opcode,
    output logic [5:0]  function_val,
    output logic        imem_req,
    output logic        ir_write,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_write,
    output logic        pc_sel,
    output logic [2:0]  state,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   ir_q;
    logic [CW-1:0] wait_q;
    logic [15:0]   count_q;
    logic          retire;
    logic          timeout;

    assign timeout = (wait_q == WAIT_LAST);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_write = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        retire   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (ir_q[31:26] == HALT_OPCODE) state_d = S_HALT;
                else                            state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_en = 1'b1;
                if (data_read && data_write) begin
                    state_d = S_FAULT;
                end else if (data_read || data_write) begin
                    state_d = S_MEMORY;
                end else if (reg_write) begin
                    state_d = S_WRITEBACK;
                end else begin
                    pc_write = 1'b1;
                    pc_sel   = (branch_type != 3'd0) && branch_taken;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = data_write;
                if (dmem_ready) begin
                    if (data_write) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                rf_we    = 1'b1;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= 32'd0;
            wait_q  <= '0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (ir_write) ir_q <= instr;
            // Counter restarts on every state change, so entry into a wait state sees 0.
            if (state_d != state_q)
                wait_q <= '0;
            else if (state_q == S_FETCH || state_q == S_MEMORY)
                wait_q <= wait_q + CW'(1);
            count_q <= count_q + 16'(retire);
        end
    end

    assign opcode       = ir_q[31:26];
    assign function_val = ir_q[5:0];
    assign state        = state_q;
    assign busy         = !(state_q == S_IDLE || state_q == S_HALT ||
                            state_q == S_FAULT);
    assign halted       = (state_q == S_HALT);
    assign fault        = (state_q == S_FAULT);
    assign instr_count  = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer against a per-instruction
// state-trace and strobe-count reference model.
module tb_multicycle_sequencer;

    localparam int TO = 15;
    localparam int K_ALU = 0, K_RT = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                   K_HALT = 5, K_ILL = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic        reg_write = 1'b0;
    logic [2:0]  branch_type = 3'd0;
    logic        branch_taken = 1'b0;
    logic [5:0]  opcode;
    logic [5:0]  function_val;
    logic        imem_req, ir_write, alu_en, dmem_req, dmem_we, rf_we;
    logic        pc_write, pc_sel, busy, halted, fault;
    logic [2:0]  state;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;
    int model_cnt = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .HALT_OPCODE(6'd63)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .data_read(data_read), .data_write(data_write),
        .reg_write(reg_write), .branch_type(branch_type),
        .branch_taken(branch_taken), .opcode(opcode),
        .function_val(function_val), .imem_req(imem_req),
        .ir_write(ir_write), .alu_en(alu_en), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .rf_we(rf_we), .pc_write(pc_write),
        .pc_sel(pc_sel), .state(state), .busy(busy), .halted(halted),
        .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_chk();
        rst_n = 1'b0;
        start = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_count", 32'(instr_count), 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_fn", 32'(function_val), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({imem_req, ir_write, alu_en, dmem_req,
                                dmem_we, rf_we, pc_write, pc_sel}), 0);
        rst_n = 1'b1;
        model_cnt = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_fetch", 32'(state), 1);
    endtask

    task automatic run_instr(input int kind, input int iw, input int dw,
                             input int btype, input bit taken);
        logic [31:0] w;
        int exp_q[$];
        int obs_q[$];
        int fc, mc, nf, nm, n;
        int c_rf, c_dreq, c_dwe, c_pcw, c_pcs, c_irw, c_alu;
        bit retire, is_mem, fetched;
        w = $urandom;
        case (kind)
            K_RT:    begin w[31:26] = 6'd0; w[5:0] = 6'd32; end
            K_LD:    w[31:26] = 6'd35;
            K_ST:    w[31:26] = 6'd43;
            K_BR:    w[31:26] = 6'd4;
            K_HALT:  w[31:26] = 6'd63;
            K_ILL:   w[31:26] = 6'd50;
            default: w[31:26] = 6'd8;
        endcase
        instr = w;
        data_read = (kind == K_LD || kind == K_ILL);
        data_write = (kind == K_ST || kind == K_ILL);
        reg_write = (kind == K_RT || kind == K_LD);
        branch_type = (kind == K_BR) ? 3'(btype) : 3'd0;
        branch_taken = (kind == K_BR) ? taken : 1'($urandom);
        is_mem = (kind == K_LD || kind == K_ST);
        fetched = (iw < TO);
        nf = fetched ? iw + 1 : TO;
        nm = (dw < TO) ? dw + 1 : TO;
        for (int i = 0; i < nf; i++) exp_q.push_back(1);
        if (!fetched) exp_q.push_back(7);
        else begin
            exp_q.push_back(2);
            if (kind == K_HALT) exp_q.push_back(6);
            else begin
                exp_q.push_back(3);
                if (kind == K_ILL) exp_q.push_back(7);
                else if (is_mem) begin
                    for (int i = 0; i < nm; i++) exp_q.push_back(4);
                    if (dw >= TO) exp_q.push_back(7);
                    else if (kind == K_LD) exp_q.push_back(5);
                end else if (kind == K_RT) exp_q.push_back(5);
            end
        end
        retire = !(exp_q[$] == 6 || exp_q[$] == 7);
        fc = 0; mc = 0;
        c_rf = 0; c_dreq = 0; c_dwe = 0; c_pcw = 0;
        c_pcs = 0; c_irw = 0; c_alu = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            imem_ready = (state == 3'd1 && fc == iw);
            dmem_ready = (state == 3'd4 && mc == dw);
            #1;
            obs_q.push_back(int'(state));
            c_rf += int'(rf_we);
            c_dreq += int'(dmem_req);
            c_dwe += int'(dmem_we);
            c_pcw += int'(pc_write);
            c_pcs += int'(pc_sel);
            c_irw += int'(ir_write);
            c_alu += int'(alu_en);
            if (state == 3'd2) begin
                chk("opcode", 32'(opcode), 32'(w[31:26]));
                chk("function_val", 32'(function_val), 32'(w[5:0]));
            end
            if (state == 3'd1) fc++;
            if (state == 3'd4) mc++;
            if (pc_write || state == 3'd6 || state == 3'd7) break;
        end
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        chk("trace_len", 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("trace[%0d]", i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk("ir_write_cycles", 32'(c_irw), fetched ? 1 : 0);
        chk("alu_en_cycles", 32'(c_alu), (fetched && kind != K_HALT) ? 1 : 0);
        chk("rf_we_cycles", 32'(c_rf),
            (retire && (kind == K_RT || kind == K_LD)) ? 1 : 0);
        chk("dmem_req_cycles", 32'(c_dreq), (fetched && is_mem) ? nm : 0);
        chk("dmem_we_cycles", 32'(c_dwe),
            (fetched && kind == K_ST) ? nm : 0);
        chk("pc_write_cycles", 32'(c_pcw), retire ? 1 : 0);
        chk("pc_sel_cycles", 32'(c_pcs),
            (retire && kind == K_BR && taken) ? 1 : 0);
        if (retire) model_cnt++;
        chk("instr_count", 32'(instr_count), 32'(16'(model_cnt)));
    endtask

    initial begin
        int k, iw, dw;
        reset_chk();
        do_start();
        run_instr(K_RT, 0, 0, 0, 1'b0);
        run_instr(K_LD, 0, 3, 0, 1'b0);
        run_instr(K_ST, 0, 0, 0, 1'b0);
        run_instr(K_BR, 0, 0, 1, 1'b1);
        run_instr(K_BR, 0, 0, 1, 1'b0);
        run_instr(K_ALU, TO - 1, 0, 0, 1'b0);
        run_instr(K_LD, 2, TO - 1, 0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 4);
            iw = ($urandom_range(0, 4) == 0) ? TO - 1 : $urandom_range(0, 3);
            dw = ($urandom_range(0, 4) == 0) ? TO - 1 : $urandom_range(0, 3);
            run_instr(k, iw, dw, $urandom_range(1, 7), 1'($urandom));
        end

        run_instr(K_HALT, 1, 0, 0, 1'b0);
        chk("halted", 32'(halted), 1);
        chk("halt_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        chk("halt_sticky", 32'(state), 6);
        chk("halt_count", 32'(instr_count), 32'(16'(model_cnt)));

        reset_chk();
        do_start();
        run_instr(K_ALU, TO + 5, 0, 0, 1'b0);
        chk("fetch_fault", 32'(fault), 1);
        chk("fault_busy", 32'(busy), 0);

        reset_chk();
        do_start();
        run_instr(K_RT, 0, 0, 0, 1'b0);
        run_instr(K_LD, 0, TO + 5, 0, 1'b0);
        chk("mem_fault", 32'(state), 7);

        reset_chk();
        do_start();
        run_instr(K_ILL, 0, 0, 0, 1'b0);
        chk("illegal_fault", 32'(fault), 1);

        reset_chk();
        do_start();
        instr = {6'd43, 26'h1234};
        data_read = 1'b0;
        data_write = 1'b1;
        reg_write = 1'b0;
        branch_type = 3'd0;
        @(negedge clk);
        imem_ready = 1'b1;
        @(posedge clk);
        #1 imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_state", 32'(state), 4);
        chk("pre_rst_dmem_we", 32'(dmem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 0);
        chk("async_rst_dmem_req", 32'(dmem_req), 0);
        chk("async_rst_writes", 32'({dmem_we, rf_we, pc_write}), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_state", 32'(state), 0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
